// File: rtl/c_top.sv
// Memory-access stage: ALU passthrough, word loads/stores, and a small
// direct-mapped, write-through, no-write-allocate data cache.
module c_top #(
   parameter int unsigned IDX_W = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        a_ready,
   input  logic [31:0] ac_pc,
   input  logic [4:0]  ac_write_sel,
   input  logic        ac_is_load,
   input  logic        ac_is_store,
   input  logic        ac_is_wb,
   input  logic [31:0] ALU_result,
   input  logic [31:0] ac_store_data,
   output logic        c_ready,
   output logic        cw_valid,
   output logic [31:0] cw_pc,
   output logic [4:0]  cw_write_sel,
   output logic        cw_is_wb,
   output logic [31:0] cw_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned Lines = 1 << IDX_W;
   localparam int unsigned TagW  = 30 - IDX_W;

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e state_q, state_d;

   // Cache storage; only the valid bits need a reset.
   logic [Lines-1:0] valid_q;
   logic [TagW-1:0]  tag_q  [Lines];
   logic [31:0]      data_q [Lines];

   // Instruction fields latched at accept, used when a WAIT completes.
   logic [31:0] lat_pc_q, lat_pc_d;
   logic [4:0]  lat_sel_q, lat_sel_d;
   logic        lat_wb_q, lat_wb_d;
   logic        lat_store_q, lat_store_d;
   logic [31:0] lat_alu_q, lat_alu_d;

   logic        cw_valid_q, cw_valid_d;
   logic [31:0] cw_pc_q, cw_pc_d;
   logic [4:0]  cw_sel_q, cw_sel_d;
   logic        cw_wb_q, cw_wb_d;
   logic [31:0] cw_data_q, cw_data_d;

   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   logic             fill_en, upd_en;
   logic [IDX_W-1:0] ac_idx, wt_idx;
   logic [TagW-1:0]  ac_tag, wt_tag;
   logic             ac_hit, wt_hit, ac_needs_mem;

   // ac_* lookup uses the live address; the WAIT lookup uses the held mem_addr.
   assign ac_idx = ALU_result[IDX_W+1:2];
   assign ac_tag = ALU_result[31:IDX_W+2];
   assign wt_idx = mem_addr_q[IDX_W+1:2];
   assign wt_tag = mem_addr_q[31:IDX_W+2];
   assign ac_hit = valid_q[ac_idx] && (tag_q[ac_idx] == ac_tag);
   assign wt_hit = valid_q[wt_idx] && (tag_q[wt_idx] == wt_tag);

   assign ac_needs_mem = ac_is_store || (ac_is_load && !ac_hit);
   assign c_ready      = (state_q == StIdle) && !(a_ready && ac_needs_mem);

   assign cw_valid     = cw_valid_q;
   assign cw_pc        = cw_pc_q;
   assign cw_write_sel = cw_sel_q;
   assign cw_is_wb     = cw_wb_q;
   assign cw_data      = cw_data_q;
   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;

   // Next-state logic: accept in IDLE, complete the memory access in WAIT.
   always_comb begin
      state_d     = state_q;
      lat_pc_d    = lat_pc_q;
      lat_sel_d   = lat_sel_q;
      lat_wb_d    = lat_wb_q;
      lat_store_d = lat_store_q;
      lat_alu_d   = lat_alu_q;
      cw_valid_d  = 1'b0;
      cw_pc_d     = cw_pc_q;
      cw_sel_d    = cw_sel_q;
      cw_wb_d     = cw_wb_q;
      cw_data_d   = cw_data_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      fill_en     = 1'b0;
      upd_en      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (a_ready) begin
               lat_pc_d    = ac_pc;
               lat_sel_d   = ac_write_sel;
               lat_wb_d    = ac_is_wb;
               lat_store_d = ac_is_store;
               lat_alu_d   = ALU_result;
               if (ac_needs_mem) begin
                  state_d     = StWait;
                  mem_req_d   = 1'b1;
                  mem_we_d    = ac_is_store;
                  mem_addr_d  = {ALU_result[31:2], 2'b00};
                  mem_wdata_d = ac_store_data;
               end else begin
                  cw_valid_d = 1'b1;
                  cw_pc_d    = ac_pc;
                  cw_sel_d   = ac_write_sel;
                  cw_wb_d    = ac_is_wb;
                  cw_data_d  = ac_is_load ? data_q[ac_idx] : ALU_result;
               end
            end
         end
         StWait: begin
            if (mem_ack) begin
               state_d    = StIdle;
               mem_req_d  = 1'b0;
               cw_valid_d = 1'b1;
               cw_pc_d    = lat_pc_q;
               cw_sel_d   = lat_sel_q;
               cw_wb_d    = lat_wb_q;
               cw_data_d  = lat_store_q ? lat_alu_q : mem_rdata;
               fill_en    = !lat_store_q;
               upd_en     = lat_store_q && wt_hit;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Pipeline state and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         lat_pc_q    <= '0;
         lat_sel_q   <= '0;
         lat_wb_q    <= 1'b0;
         lat_store_q <= 1'b0;
         lat_alu_q   <= '0;
         cw_valid_q  <= 1'b0;
         cw_pc_q     <= '0;
         cw_sel_q    <= '0;
         cw_wb_q     <= 1'b0;
         cw_data_q   <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         lat_pc_q    <= lat_pc_d;
         lat_sel_q   <= lat_sel_d;
         lat_wb_q    <= lat_wb_d;
         lat_store_q <= lat_store_d;
         lat_alu_q   <= lat_alu_d;
         cw_valid_q  <= cw_valid_d;
         cw_pc_q     <= cw_pc_d;
         cw_sel_q    <= cw_sel_d;
         cw_wb_q     <= cw_wb_d;
         cw_data_q   <= cw_data_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Valid bits: cleared on reset, set by a load fill.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '0;
      end else if (fill_en) begin
         valid_q[wt_idx] <= 1'b1;
      end
   end

   // Tag/data arrays: fill on load completion, write-through update on store hit.
   always_ff @(posedge clock) begin
      if (fill_en) begin
         tag_q[wt_idx]  <= wt_tag;
         data_q[wt_idx] <= mem_rdata;
      end else if (upd_en) begin
         data_q[wt_idx] <= mem_wdata_q;
      end
   end

endmodule

// File: tb/tb_c_top.sv
// Directed bench for c_top: passthrough, load miss/hit, stores, aliasing, reset in WAIT.
module tb_c_top;

   logic        clock = 1'b0;
   logic        reset;
   logic        a_ready;
   logic [31:0] ac_pc;
   logic [4:0]  ac_write_sel;
   logic        ac_is_load, ac_is_store, ac_is_wb;
   logic [31:0] ALU_result, ac_store_data;
   logic        c_ready, cw_valid, cw_is_wb;
   logic [31:0] cw_pc, cw_data;
   logic [4:0]  cw_write_sel;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_checks = 0;
   int n_errors = 0;

   c_top #(.IDX_W(4)) dut (
      .clock(clock), .reset(reset), .a_ready(a_ready), .ac_pc(ac_pc),
      .ac_write_sel(ac_write_sel), .ac_is_load(ac_is_load), .ac_is_store(ac_is_store),
      .ac_is_wb(ac_is_wb), .ALU_result(ALU_result), .ac_store_data(ac_store_data),
      .c_ready(c_ready), .cw_valid(cw_valid), .cw_pc(cw_pc), .cw_write_sel(cw_write_sel),
      .cw_is_wb(cw_is_wb), .cw_data(cw_data), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drop();
      a_ready = 1'b0; ac_is_load = 1'b0; ac_is_store = 1'b0; ac_is_wb = 1'b0;
   endtask

   task automatic present(input logic [31:0] pc, input logic [4:0] sel, input logic ld,
                          input logic st, input logic wb, input logic [31:0] alu,
                          input logic [31:0] sd);
      a_ready = 1'b1; ac_pc = pc; ac_write_sel = sel; ac_is_load = ld; ac_is_store = st;
      ac_is_wb = wb; ALU_result = alu; ac_store_data = sd;
   endtask

   // Non-memory op: retires one cycle after accept, fields hold afterwards.
   task automatic do_alu(input logic [31:0] pc, input logic [4:0] sel, input logic [31:0] alu);
      present(pc, sel, 1'b0, 1'b0, 1'b1, alu, 32'h0);
      #1 check("alu_c_ready", c_ready, 1);
      @(negedge clock); drop();
      check("alu_cw_valid", cw_valid, 1);
      check("alu_cw_data", cw_data, alu);
      check("alu_cw_sel", cw_write_sel, sel);
      check("alu_cw_pc", cw_pc, pc);
      check("alu_cw_wb", cw_is_wb, 1);
      check("alu_mem_req", mem_req, 0);
      check("alu_c_ready_after", c_ready, 1);
      @(negedge clock);
      check("idle_no_retire", cw_valid, 0);
      check("cw_data_hold", cw_data, alu);
   endtask

   // Load that must hit: c_ready stays high, retires next cycle, no memory traffic.
   task automatic do_hit(input logic [31:0] addr, input logic [31:0] exp);
      present(32'h40, 5'd7, 1'b1, 1'b0, 1'b1, addr, 32'h0);
      #1 check("hit_c_ready", c_ready, 1);
      @(negedge clock); drop();
      check("hit_cw_valid", cw_valid, 1);
      check("hit_cw_data", cw_data, exp);
      check("hit_mem_req", mem_req, 0);
   endtask

   // Miss or store: request next cycle, held until ack after `dly` cycles, retire after ack.
   task automatic do_mem(input logic [31:0] addr, input logic st, input logic [31:0] sd,
                         input logic [31:0] rdata, input int dly, input logic [31:0] exp);
      present(32'h80, 5'd9, !st, st, !st, addr, sd);
      #1 check("mem_c_ready", c_ready, 0);
      @(negedge clock); drop();
      check("mem_req", mem_req, 1);
      check("mem_we", mem_we, st);
      check("mem_addr", mem_addr, {addr[31:2], 2'b00});
      check("mem_wdata", mem_wdata, sd);
      for (int i = 1; i < dly; i++) begin
         @(negedge clock);
         check("mem_req_held", mem_req, 1);
         check("mem_addr_held", mem_addr, {addr[31:2], 2'b00});
         check("wait_c_ready", c_ready, 0);
         check("wait_cw_valid", cw_valid, 0);
      end
      mem_ack = 1'b1; mem_rdata = rdata;
      @(negedge clock); mem_ack = 1'b0; mem_rdata = 32'h0;
      check("ack_mem_req", mem_req, 0);
      check("ack_cw_valid", cw_valid, 1);
      check("ack_cw_data", cw_data, exp);
      check("ack_cw_pc", cw_pc, 32'h80);
      check("ack_c_ready", c_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
      ac_pc = 32'h0; ac_write_sel = 5'd0; ALU_result = 32'h0; ac_store_data = 32'h0;
      drop();
      @(negedge clock); @(negedge clock);
      check("rst_cw_valid", cw_valid, 0);
      check("rst_cw_data", cw_data, 0);
      check("rst_cw_pc", cw_pc, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_c_ready", c_ready, 1);
      reset = 1'b0;
      @(negedge clock);

      do_alu(32'h10, 5'd5, 32'h1234);
      // Load miss then unaligned hit on the same word.
      do_mem(32'h100, 1'b0, 32'h0, 32'hDEADBEEF, 3, 32'hDEADBEEF);
      do_hit(32'h103, 32'hDEADBEEF);
      // Store hit updates the line; cw_data carries ALU_result. Back-to-back ALU op.
      do_mem(32'h100, 1'b1, 32'h5, 32'hFFFF_FFFF, 1, 32'h100);
      do_alu(32'h14, 5'd3, 32'hA5A5_0001);
      do_hit(32'h100, 32'h5);
      // Store miss does not allocate.
      do_mem(32'h200, 1'b1, 32'h77, 32'h0, 2, 32'h200);
      do_mem(32'h200, 1'b0, 32'h0, 32'h2222, 1, 32'h2222);
      do_hit(32'h200, 32'h2222);
      // 0x100, 0x140 and 0x200 all map to index 0.
      do_mem(32'h100, 1'b0, 32'h0, 32'h1111, 1, 32'h1111);
      do_mem(32'h140, 1'b0, 32'h0, 32'h1400, 2, 32'h1400);
      do_mem(32'h100, 1'b0, 32'h0, 32'h1112, 1, 32'h1112);

      // Stray ack in IDLE.
      mem_ack = 1'b1;
      @(negedge clock); mem_ack = 1'b0;
      check("stray_mem_req", mem_req, 0);
      check("stray_cw_valid", cw_valid, 0);

      // Reset during WAIT drops the pending load and clears the cache.
      present(32'h90, 5'd4, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0);
      @(negedge clock); drop();
      check("rw_mem_req", mem_req, 1);
      reset = 1'b1;
      @(negedge clock); reset = 1'b0;
      check("rw_mem_req_off", mem_req, 0);
      check("rw_cw_valid", cw_valid, 0);
      check("rw_c_ready", c_ready, 1);
      mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      @(negedge clock); mem_ack = 1'b0;
      check("late_ack_cw_valid", cw_valid, 0);
      check("late_ack_mem_req", mem_req, 0);
      do_mem(32'h100, 1'b0, 32'h0, 32'h3333, 2, 32'h3333);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/c_top.md
Name: c_top

Overview:
- Memory-access (C) stage of the 32-bit RISC-V pipeline; sits downstream of the execute (A) stage on the ac_*/a_ready/c_ready interface.
- Consumes the instruction the A stage presents, passes ALU results through, and performs word loads and stores against external memory.
- Contains a small direct-mapped, write-through, no-write-allocate data cache.
- Drives c_ready back to the A stage to stall it on misses and stores. Presents retired results to writeback on cw_* outputs.

Parameters:
- IDX_W, 4, cache index width; the cache has 2^IDX_W one-word lines.

Ports:
- clock  input  1  pipeline clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- a_ready  input  1  ac_* carries a new instruction this cycle
- ac_pc  input  32  PC of the presented instruction
- ac_write_sel  input  5  destination register
- ac_is_load  input  1  instruction is a word load
- ac_is_store  input  1  instruction is a word store
- ac_is_wb  input  1  instruction writes a register
- ALU_result  input  32  ALU result; this is the byte address for loads and stores
- ac_store_data  input  32  store data; the A stage adds this port
- c_ready  output  1  combinational; C can accept the ac_* instruction this cycle
- cw_valid  output  1  one-cycle pulse; an instruction retires this cycle
- cw_pc  output  32  retired PC
- cw_write_sel  output  5  retired destination register
- cw_is_wb  output  1  retired instruction writes a register
- cw_data  output  32  load data, or ALU_result for non-load instructions
- mem_req  output  1  memory request; held until acknowledged
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  32  word-aligned byte address
- mem_wdata  output  32  write data
- mem_ack  input  1  memory completes the request this cycle
- mem_rdata  input  32  read data, valid when mem_ack=1

Behaviour:
- Reset state:
  - all outputs 0 except c_ready;
  - all cache valid bits cleared;
  - FSM goes to IDLE.
- Reset wins over every other event, including mid-WAIT: mem_req is 0 the next cycle and any pending instruction is dropped.
- Address mapping:
  - ALU_result[1:0] are ignored; mem_addr[1:0] is always 00;
  - index = addr[IDX_W+1:2];
  - tag = addr[31:IDX_W+2].
- hit = valid[index] && tag match. It is evaluated combinationally on the current ac_* address.
- c_ready = (state==IDLE) && !(a_ready && (ac_is_store || (ac_is_load && !hit))).
- Accept rule: C accepts the instruction on the edge where state==IDLE and a_ready=1. All ac_* fields are latched on that edge.
- The A stage holds ac_* stable and drops a_ready after a cycle with c_ready=0. C must not re-accept the held instruction.
- FSM has two states, IDLE and WAIT.
- IDLE, instruction that is neither load nor store:
  - cw_valid=1 the next cycle;
  - cw_data=ALU_result;
  - cw_* fields are copies of the latched ac_* fields.
- IDLE, load hit:
  - retires the next cycle, with cw_data = cached word;
  - no memory traffic.
- IDLE, load miss or any store:
  - go to WAIT;
  - mem_req=1 the next cycle, with mem_we=ac_is_store, the address, and mem_wdata=ac_store_data.
- WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata are held constant until the edge that samples mem_ack=1;
  - mem_ack may arrive in the first cycle mem_req is high;
  - c_ready=0 throughout.
- On the ack edge:
  - mem_req drops to 0;
  - state returns to IDLE;
  - cw_valid=1 the next cycle, with cw_data=mem_rdata for a load and the latched ALU_result for a store;
  - load: the line is filled (valid, tag, data);
  - store that hits: the cached word is updated;
  - store that misses: the cache is unchanged (no allocate).
- Latency:
  - non-memory instructions and load hits retire 1 cycle after accept;
  - misses and stores retire 1 cycle after mem_ack.
- Back-to-back: in the cycle cw_valid pulses after a WAIT, state is IDLE, so C can accept a new instruction in that same cycle.
- Stray inputs: mem_ack while mem_req=0 is ignored. a_ready=0 in IDLE produces no retire.
- cw_* fields hold their last value when cw_valid=0.

Test Plan:
- Reset: assert reset with a_ready=0 -> all outputs 0 and c_ready=1; load 0x100 after reset misses.
- ALU passthrough: accept ALU_result=0x1234, ac_write_sel=5, ac_is_wb=1 -> next cycle cw_valid=1, cw_data=0x1234, cw_write_sel=5, mem_req=0, c_ready stays 1.
- Load miss then hit: load 0x100 -> c_ready=0; mem_req=1, mem_we=0, mem_addr=0x100 next cycle; ack after 3 cycles with 0xDEADBEEF -> cw_data=0xDEADBEEF one cycle after ack. Second load 0x103 -> hit, retires 1 cycle after accept with 0xDEADBEEF, no mem_req.
- Stores: store 0x5 to 0x100 (line cached) -> mem_we=1, mem_wdata=0x5; a following load 0x100 hits with 0x5. Store to 0x200 (uncached) -> a following load 0x200 misses.
- Aliasing with IDX_W=4: load 0x100 then load 0x140 -> both miss; reload 0x100 misses again.
- Reset in WAIT: load miss, reset asserted before ack -> mem_req=0 next cycle, no cw_valid; late mem_ack ignored; load 0x100 misses afterwards.
